// File: rtl/rx_block_packer.sv
`default_nettype none
// ============================================================================
// Module   : rx_block_packer
// Purpose  : Packs Rx FIFO bytes MSB-first into cipher blocks and holds each
//            finished block for the cipher core's valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module rx_block_packer #(
    parameter int DATA_W          = 8,
    parameter int BYTES_PER_BLOCK = 8,
    parameter int CNT_W           = $clog2(BYTES_PER_BLOCK + 1)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              read_fifo,
    input  logic [DATA_W-1:0]                 rx_data,
    input  logic                              is_encrypt,
    output logic                              accepted,
    output logic [DATA_W*BYTES_PER_BLOCK-1:0] block_out,
    output logic                              block_is_encrypt,
    output logic                              block_valid,
    input  logic                              block_ready,
    output logic [CNT_W-1:0]                  fill_count
);

    localparam int             BLOCK_W   = DATA_W * BYTES_PER_BLOCK;
    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(BYTES_PER_BLOCK - 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(BYTES_PER_BLOCK);

    typedef enum logic [0:0] {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic                 accepted_q, accepted_d;
    logic [BLOCK_W-1:0]   block_q, block_d;
    logic                 mode_q, mode_d;
    logic [CNT_W-1:0]     fill_count_q, fill_count_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= FILL;
            accepted_q   <= 1'b0;
            block_q      <= '0;
            mode_q       <= 1'b0;
            fill_count_q <= '0;
        end else begin
            state_q      <= state_d;
            accepted_q   <= accepted_d;
            block_q      <= block_d;
            mode_q       <= mode_d;
            fill_count_q <= fill_count_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        accepted_d   = 1'b0;
        block_d      = block_q;
        mode_d       = mode_q;
        fill_count_d = fill_count_q;

        case (state_q)
            FILL: begin
                if (read_fifo) begin
                    // Slot k lives k bytes below the MSB end of the block.
                    for (int i = 0; i < BYTES_PER_BLOCK; i++) begin
                        if (fill_count_q == CNT_W'(i)) begin
                            block_d[BLOCK_W-1-i*DATA_W -: DATA_W] = rx_data;
                        end
                    end
                    if (fill_count_q == '0) begin
                        mode_d = is_encrypt;
                    end
                    accepted_d   = 1'b1;
                    fill_count_d = fill_count_q + CNT_W'(1);
                    if (fill_count_q == LAST_SLOT) begin
                        state_d      = HOLD;
                        fill_count_d = FULL_CNT;
                    end
                end
            end
            HOLD: begin
                // A read in the transfer cycle is refused; the MCU retries.
                if (block_ready) begin
                    state_d      = FILL;
                    fill_count_d = '0;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    assign accepted         = accepted_q;
    assign block_out        = block_q;
    assign block_is_encrypt = mode_q;
    assign block_valid      = (state_q == HOLD);
    assign fill_count       = fill_count_q;

endmodule
`default_nettype wire
